// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI-Lite single-outstanding master.
package axi_lite_master_pkg;

  // Controller state encoding.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrAwW = 3'd1;
  localparam logic [2:0] StWrB   = 3'd2;
  localparam logic [2:0] StRdAr  = 3'd3;
  localparam logic [2:0] StRdR   = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  // AXI BRESP/RRESP codes.
  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExOkay = 2'd1,
    RespSlvErr = 2'd2,
    RespDecErr = 2'd3
  } axi_resp_e;

  localparam int unsigned DefaultTimeout = 255;

  // Any response other than OKAY is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// Per-state wait counter: clears on state entry, counts while enabled, flags Limit.
module axi_wait_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Limit < 1) ? 1 : $clog2(Limit + 1);
  localparam logic [CntW-1:0] LimitCnt = CntW'(Limit);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == LimitCnt);

  // Next count: clear wins, otherwise count up and hold once the limit is hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one simple request into one AXI transaction at a time.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                m_axi_aclk_i,
  input  logic                m_axi_aresetn_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic                resp_timeout_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [DATA_W-1:0]   m_axi_wdata_o,
  output logic [DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  input  logic [1:0]          m_axi_bresp_i,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i,
  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              timeout_q, timeout_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              waiting, expired;

  assign waiting = (state_q == StWrAwW) || (state_q == StWrB) ||
                   (state_q == StRdAr)  || (state_q == StRdR);

  axi_wait_timer #(
    .Limit (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (m_axi_aclk_i),
    .rst_ni    (m_axi_aresetn_i),
    .clear_i   (state_d != state_q),
    .enable_i  (waiting),
    .expired_o (expired)
  );

  // Handshake outputs are state-derived; an expired wait withdraws them before leaving.
  always_comb begin
    req_ready_o     = (state_q == StIdle) && m_axi_aresetn_i;
    m_axi_awvalid_o = (state_q == StWrAwW) && !aw_done_q && !expired;
    m_axi_wvalid_o  = (state_q == StWrAwW) && !w_done_q && !expired;
    m_axi_bready_o  = (state_q == StWrB) && !expired;
    m_axi_arvalid_o = (state_q == StRdAr) && !expired;
    m_axi_rready_o  = (state_q == StRdR) && !expired;
    m_axi_awaddr_o  = addr_q;
    m_axi_araddr_o  = addr_q;
    m_axi_wdata_o   = wdata_q;
    m_axi_wstrb_o   = wstrb_q;
    resp_valid_o    = (state_q == StResp);
    resp_err_o      = resp_valid_o && (timeout_q || resp_is_err(resp_q));
    resp_timeout_o  = resp_valid_o && timeout_q;
    resp_rdata_o    = (resp_valid_o && !we_q) ? rdata_q : '0;
  end

  // Next-state and capture logic for the single outstanding transaction.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          rdata_d   = '0;
          resp_d    = '0;
          timeout_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we_i ? StWrAwW : StRdAr;
        end
      end
      StWrAwW: begin
        if (expired) begin
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          aw_done_d = aw_done_q || m_axi_awready_i;
          w_done_d  = w_done_q || m_axi_wready_i;
          if (aw_done_d && w_done_d) state_d = StWrB;
        end
      end
      StWrB: begin
        if (expired) begin
          timeout_d = 1'b1;
          state_d   = StResp;
        end else if (m_axi_bvalid_i) begin
          resp_d  = m_axi_bresp_i;
          state_d = StResp;
        end
      end
      StRdAr: begin
        if (expired) begin
          timeout_d = 1'b1;
          state_d   = StResp;
        end else if (m_axi_arready_i) begin
          state_d = StRdR;
        end
      end
      StRdR: begin
        if (expired) begin
          timeout_d = 1'b1;
          state_d   = StResp;
        end else if (m_axi_rvalid_i) begin
          rdata_d = m_axi_rdata_i;
          resp_d  = m_axi_rresp_i;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
    if (!m_axi_aresetn_i) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable slave plus latency/result model.
module tb_axi_lite_master;

  localparam int T = 8;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_err = 0;

  axi_lite_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (T)
  ) u_dut (
    .m_axi_aclk_i    (clk),
    .m_axi_aresetn_i (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .req_wstrb_i     (req_wstrb),
    .resp_valid_o    (resp_valid),
    .resp_rdata_o    (resp_rdata),
    .resp_err_o      (resp_err),
    .resp_timeout_o  (resp_timeout),
    .m_axi_awaddr_o  (awaddr),
    .m_axi_awvalid_o (awvalid),
    .m_axi_awready_i (awready),
    .m_axi_wdata_o   (wdata),
    .m_axi_wstrb_o   (wstrb),
    .m_axi_wvalid_o  (wvalid),
    .m_axi_wready_i  (wready),
    .m_axi_bresp_i   (bresp),
    .m_axi_bvalid_i  (bvalid),
    .m_axi_bready_o  (bready),
    .m_axi_araddr_o  (araddr),
    .m_axi_arvalid_o (arvalid),
    .m_axi_arready_i (arready),
    .m_axi_rdata_i   (rdata),
    .m_axi_rresp_i   (rresp),
    .m_axi_rvalid_i  (rvalid),
    .m_axi_rready_o  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0;  rvalid = 1'b0;
    bresp = 2'($urandom); rresp = 2'($urandom); rdata = $urandom;
  endtask

  // Every DUT output that must be zero while reset is held.
  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {awvalid, wvalid, bready, arvalid, rready, req_ready,
                             resp_valid, resp_err, resp_timeout}, '0);
    check_eq({tag, "_dat"}, {awaddr, wdata, wstrb, araddr, resp_rdata}, '0);
  endtask

  // Idle cycles with stray B/R responses that must be ignored.
  task automatic idle_stray(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      slave_idle();
      bvalid = 1'b1; bresp = 2'd3;
      rvalid = 1'b1; rresp = 2'd3;
      check_eq("stray_idle", {resp_valid, req_ready}, 2'b01);
    end
  endtask

  // d1: AW (write) or AR (read) ready delay; d2: W ready delay; d3: B/R valid delay.
  // A delay >= T means the slave never answers inside the wait window.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int d1, input int d2, input int d3,
                         input logic [1:0] code, input logic [31:0] rd, input logic hold,
                         input int rst_at);
    int m, lat, c;
    int awc, wc, arc, aw_hs, w_hs, ar_hs, b_hs, r_hs, b_cnt, r_cnt;
    bit to, seen, addr_done, proto_bad, pay_bad, rdy_bad;
    logic exp_err;
    logic [31:0] exp_rd;
    // Reference: each wait phase lasts (delay + 1) cycles, or T + 1 when it expires.
    m = we ? ((d1 > d2) ? d1 : d2) : d1;
    if (m >= T) begin
      lat = T + 2; to = 1;
    end else if (d3 >= T) begin
      lat = m + T + 3; to = 1;
    end else begin
      lat = m + d3 + 3; to = 0;
    end
    exp_err = to || (code != 2'd0);
    exp_rd  = (we || to) ? 32'd0 : rd;
    {awc, wc, arc, aw_hs, w_hs, ar_hs, b_hs, r_hs, b_cnt, r_cnt} = '0;
    {seen, addr_done, proto_bad, pay_bad, rdy_bad} = '0;

    @(negedge clk);
    slave_idle();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
    check_eq("req_ready_idle", req_ready, 1'b1);
    c = 0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_valid = hold; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
      end
      if (c == rst_at) begin
        check_eq("pre_rst_bready", bready, 1'b1);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rst_rel_ready", req_ready, 1'b1);
        return;
      end
      slave_idle();
      if (req_ready) rdy_bad = 1;
      if (resp_valid) begin
        seen = 1;
        if (awvalid || wvalid || bready || arvalid || rready) proto_bad = 1;
      end else begin
        if (we && (arvalid || rready)) proto_bad = 1;
        if (!we && (awvalid || wvalid || bready)) proto_bad = 1;
        if (awvalid && awaddr != addr) pay_bad = 1;
        if (wvalid && (wdata != wd || wstrb != st)) pay_bad = 1;
        if (arvalid && araddr != addr) pay_bad = 1;
        awready = awvalid && (awc >= d1);
        wready  = wvalid && (wc >= d2);
        arready = arvalid && (arc >= d1);
        if (addr_done && we && b_cnt >= d3 && b_hs == 0) begin
          bvalid = 1'b1; bresp = code;
        end
        if (addr_done && !we && r_cnt >= d3 && r_hs == 0) begin
          rvalid = 1'b1; rresp = code; rdata = rd;
        end
        aw_hs += int'(awvalid && awready);
        w_hs  += int'(wvalid && wready);
        ar_hs += int'(arvalid && arready);
        b_hs  += int'(bvalid && bready);
        r_hs  += int'(rvalid && rready);
        awc += int'(awvalid);
        wc  += int'(wvalid);
        arc += int'(arvalid);
        if (addr_done) begin
          b_cnt++; r_cnt++;
        end
        if (we ? (aw_hs > 0 && w_hs > 0) : (ar_hs > 0)) addr_done = 1;
      end
    end
    check_eq("resp_latency", 64'(c), 64'(lat));
    check_eq("resp_err", resp_err, exp_err);
    check_eq("resp_timeout", resp_timeout, 1'(to));
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("proto_overlap", 1'(proto_bad), 1'b0);
    check_eq("payload_stable", 1'(pay_bad), 1'b0);
    check_eq("req_ready_busy", 1'(rdy_bad), 1'b0);
    if (we) begin
      check_eq("aw_cycles", 64'(awc), 64'((d1 < T) ? d1 + 1 : T));
      check_eq("w_cycles", 64'(wc), 64'((d2 < T) ? d2 + 1 : T));
      check_eq("b_count", 64'(b_hs), 64'(!to));
      check_eq("aw_w_count", 64'({aw_hs[7:0], w_hs[7:0]}),
               64'({8'((d1 < T) ? 1 : 0), 8'((d2 < T) ? 1 : 0)}));
    end else begin
      check_eq("ar_cycles", 64'(arc), 64'((d1 < T) ? d1 + 1 : T));
      check_eq("r_count", 64'(r_hs), 64'(!to));
    end
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r == 6) return T - 1;
    if (r == 7) return T;
    return 12;
  endfunction

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    check_all_zero("rst_init");
    rst_n = 1'b1;
    #1 check_eq("rst_rel_ready0", req_ready, 1'b1);

    // Directed: fast write, split AW/W, erroring read, AR timeout.
    run_txn(1'b1, 32'h2000_0000, 32'h0000_1234, 4'hF, 0, 0, 0, 2'd0, 32'h0, 1'b0, 0);
    run_txn(1'b1, 32'h2000_0000, 32'h0000_1234, 4'hF, 0, 2, 0, 2'd0, 32'h0, 1'b0, 0);
    run_txn(1'b0, 32'h2000_0004, 32'h0, 4'h0, 0, 0, 1, 2'd2, 32'hA5A5_0055, 1'b0, 0);
    run_txn(1'b0, 32'h2000_0008, 32'h0, 4'h0, 12, 0, 0, 2'd0, 32'h1111_2222, 1'b0, 0);
    // Reset in WR_B, then a normal read.
    run_txn(1'b1, 32'h3000_0000, 32'hCAFE_F00D, 4'h3, 0, 0, 12, 2'd0, 32'h0, 1'b0, 2);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h0, 1, 0, 2, 2'd0, 32'h5A5A_1234, 1'b0, 0);
    // Back-to-back with req_valid held high.
    run_txn(1'b1, 32'h4000_0000, 32'h0BAD_BEEF, 4'h5, 1, 0, 0, 2'd1, 32'h0, 1'b1, 0);
    run_txn(1'b0, 32'h4000_0004, 32'h0, 4'h0, 0, 0, 0, 2'd0, 32'h7777_8888, 1'b0, 0);
    idle_stray(3);
    // Boundary: handshake on the last allowed cycle, and write B timeout.
    run_txn(1'b1, 32'h5000_0000, 32'h1, 4'h1, T - 1, 0, T - 1, 2'd3, 32'h0, 1'b0, 0);
    run_txn(1'b1, 32'h5000_0004, 32'h2, 4'h2, 0, 1, T, 2'd0, 32'h0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic we_r, hold_r;
      we_r   = 1'($urandom);
      hold_r = ($urandom_range(0, 3) == 0);
      run_txn(we_r, $urandom, $urandom, 4'($urandom), pick_dly(), pick_dly(), pick_dly(),
              2'($urandom), $urandom, hold_r, 0);
      if (!hold_r) idle_stray($urandom_range(0, 2));
    end
    idle_stray(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
